// File: rtl/mips_decode_pkg.sv
// mips_decode_pkg: shared definitions for the MIPS decode stage.
//   - Opcode values used by the decode and legality logic.
//   - Bit positions of each instruction field.
//   - decoded_instr_t: the bundle stored in the skid buffer.
//   - Helper functions for the ZeroExtend and legal-opcode decodes.
//   - skid_state_e: occupancy states of the 2-entry buffer.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds an illegal flag to the bundle.
package mips_decode_pkg;

  localparam int INSTR_W      = 32;
  localparam int DEFAULT_PC_W = 32;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Field bit positions
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int RD_MSB     = 15;
  localparam int RD_LSB     = 11;
  localparam int SHAMT_MSB  = 10;
  localparam int SHAMT_LSB  = 6;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int JT_MSB     = 25;
  localparam int JT_LSB     = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  typedef struct packed {
    logic [5:0]              opcode;
    logic [4:0]              rs;
    logic [4:0]              rt;
    logic [4:0]              rd;
    logic [4:0]              shamt;
    logic [5:0]              funct;
    logic [15:0]             imm;
    logic                    zeroExtend;
    logic [25:0]             jumpTarget;
    logic [DEFAULT_PC_W-1:0] pc;
`ifdef DECODE_ILLEGAL_TRAP_EN
    logic                    illegal;
`endif
  } decoded_instr_t;

  // Logical immediates are zero-extended; every other immediate is sign-extended.
  function automatic logic isZeroExtendOp(input logic [5:0] op);
    logic result;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: result = 1'b1;
      default:                  result = 1'b0;
    endcase
    return result;
  endfunction

  function automatic logic isLegalOpcode(input logic [5:0] op);
    logic result;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW: result = 1'b1;
      default:                                                result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/instr_decode_stage_if.sv
// instr_decode_stage_if: fetch-side and execute-side signals of the decode stage.
//   Fetch side  : Flush, InValid, InReady, Instr, PcIn.
//   Execute side: OutValid, OutReady, Opcode, Rs, Rt, Rd, Shamt, Funct, ImmIn,
//                 ZeroExtend, JumpTarget, PcOut (+ IllegalInstr).
//   slave  modport: the decode stage itself.
//   master modport: the environment (fetch + execute) around it.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds IllegalInstr.
interface instr_decode_stage_if
  import mips_decode_pkg::*;
#(
  parameter int PC_W = mips_decode_pkg::DEFAULT_PC_W
) ();

  logic               Flush;
  logic               InValid;
  logic               InReady;
  logic [INSTR_W-1:0] Instr;
  logic [PC_W-1:0]    PcIn;
  logic               OutValid;
  logic               OutReady;
  logic [5:0]         Opcode;
  logic [4:0]         Rs;
  logic [4:0]         Rt;
  logic [4:0]         Rd;
  logic [4:0]         Shamt;
  logic [5:0]         Funct;
  logic [15:0]        ImmIn;
  logic               ZeroExtend;
  logic [25:0]        JumpTarget;
  logic [PC_W-1:0]    PcOut;
`ifdef DECODE_ILLEGAL_TRAP_EN
  logic               IllegalInstr;
`endif

  modport slave (
    input  Flush, InValid, Instr, PcIn, OutReady,
    output InReady, OutValid, Opcode, Rs, Rt, Rd, Shamt, Funct, ImmIn,
           ZeroExtend, JumpTarget, PcOut
`ifdef DECODE_ILLEGAL_TRAP_EN
    , output IllegalInstr
`endif
  );

  modport master (
    output Flush, InValid, Instr, PcIn, OutReady,
    input  InReady, OutValid, Opcode, Rs, Rt, Rd, Shamt, Funct, ImmIn,
           ZeroExtend, JumpTarget, PcOut
`ifdef DECODE_ILLEGAL_TRAP_EN
    , input IllegalInstr
`endif
  );

endinterface

// File: rtl/decode_skid_buffer.sv
// decode_skid_buffer: generic 2-entry valid/ready buffer (main + skid).
//   clk, rst_n         : clock, asynchronous active-low reset
//   flush              : empties both entries, priority over accept/emit
//   inValid/inReady    : upstream handshake (inReady registered = skid empty)
//   inData             : W-bit payload
//   outValid/outReady  : downstream handshake, outData driven from main entry
// Full throughput: the skid entry absorbs the one beat already accepted when
// downstream stalls, so inReady never depends combinationally on outReady.
module decode_skid_buffer
  import mips_decode_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         inValid,
  output logic         inReady,
  input  logic [W-1:0] inData,
  output logic         outValid,
  input  logic         outReady,
  output logic [W-1:0] outData
);

  skid_state_e  state_r;
  skid_state_e  nextState_s;
  logic [W-1:0] mainData_r;
  logic [W-1:0] skidData_r;
  logic         inReady_r;
  logic         outValid_r;
  logic         accept_s;
  logic         emit_s;
  logic         loadMain_s;
  logic         loadSkid_s;
  logic         moveSkid_s;

  assign accept_s = inValid & inReady_r;
  assign emit_s   = outValid_r & outReady;

  // Next occupancy state and entry load controls
  always_comb begin
    nextState_s = state_r;
    loadMain_s  = 1'b0;
    loadSkid_s  = 1'b0;
    moveSkid_s  = 1'b0;
    if (flush) begin
      nextState_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            nextState_s = ONE;
            loadMain_s  = 1'b1;
          end else begin
            nextState_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && emit_s) begin
            nextState_s = ONE;
            loadMain_s  = 1'b1;
          end else if (accept_s) begin
            nextState_s = TWO;
            loadSkid_s  = 1'b1;
          end else if (emit_s) begin
            nextState_s = EMPTY;
          end else begin
            nextState_s = ONE;
          end
        end
        TWO: begin
          // inReady is low here, so only an emit can change occupancy.
          if (emit_s) begin
            nextState_s = ONE;
            moveSkid_s  = 1'b1;
          end else begin
            nextState_s = TWO;
          end
        end
        default: begin
          nextState_s = EMPTY;
        end
      endcase
    end
  end

  // Occupancy state and the registered handshake flags derived from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= EMPTY;
      inReady_r  <= 1'b0;
      outValid_r <= 1'b0;
    end else begin
      state_r    <= nextState_s;
      inReady_r  <= (nextState_s != TWO);
      outValid_r <= (nextState_s != EMPTY);
    end
  end

  // Payload storage; entries keep stale data when emptied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mainData_r <= '0;
      skidData_r <= '0;
    end else begin
      if (loadMain_s) begin
        mainData_r <= inData;
      end else if (moveSkid_s) begin
        mainData_r <= skidData_r;
      end
      if (loadSkid_s) begin
        skidData_r <= inData;
      end
    end
  end

  assign inReady  = inReady_r;
  assign outValid = outValid_r;
  assign outData  = mainData_r;

endmodule

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: MIPS decode stage feeding the immediate extender.
//   clk   : stage clock
//   rst_n : asynchronous active-low reset
//   bus   : instr_decode_stage_if.slave (fetch handshake, Flush, decoded
//           fields, ImmIn/ZeroExtend, PcOut, execute handshake)
// Fields are sliced on the input side, stored as a decoded_instr_t bundle in
// a 2-entry skid buffer, and driven straight from the buffer's main entry.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN adds IllegalInstr.
module instr_decode_stage
  import mips_decode_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_decode_stage_if.slave bus
);

  decoded_instr_t inBundle_s;
  decoded_instr_t outBundle_s;

  // Field decode of the offered instruction
  always_comb begin
    inBundle_s            = '0;
    inBundle_s.opcode     = bus.Instr[OPCODE_MSB:OPCODE_LSB];
    inBundle_s.rs         = bus.Instr[RS_MSB:RS_LSB];
    inBundle_s.rt         = bus.Instr[RT_MSB:RT_LSB];
    inBundle_s.rd         = bus.Instr[RD_MSB:RD_LSB];
    inBundle_s.shamt      = bus.Instr[SHAMT_MSB:SHAMT_LSB];
    inBundle_s.funct      = bus.Instr[FUNCT_MSB:FUNCT_LSB];
    inBundle_s.imm        = bus.Instr[IMM_MSB:IMM_LSB];
    inBundle_s.zeroExtend = isZeroExtendOp(bus.Instr[OPCODE_MSB:OPCODE_LSB]);
    inBundle_s.jumpTarget = bus.Instr[JT_MSB:JT_LSB];
    inBundle_s.pc         = DEFAULT_PC_W'(bus.PcIn);
`ifdef DECODE_ILLEGAL_TRAP_EN
    inBundle_s.illegal    = ~isLegalOpcode(bus.Instr[OPCODE_MSB:OPCODE_LSB]);
`endif
  end

  decode_skid_buffer #(
    .W($bits(decoded_instr_t))
  ) uSkid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (bus.Flush),
    .inValid  (bus.InValid),
    .inReady  (bus.InReady),
    .inData   (inBundle_s),
    .outValid (bus.OutValid),
    .outReady (bus.OutReady),
    .outData  (outBundle_s)
  );

  assign bus.Opcode     = outBundle_s.opcode;
  assign bus.Rs         = outBundle_s.rs;
  assign bus.Rt         = outBundle_s.rt;
  assign bus.Rd         = outBundle_s.rd;
  assign bus.Shamt      = outBundle_s.shamt;
  assign bus.Funct      = outBundle_s.funct;
  assign bus.ImmIn      = outBundle_s.imm;
  assign bus.ZeroExtend = outBundle_s.zeroExtend;
  assign bus.JumpTarget = outBundle_s.jumpTarget;
  assign bus.PcOut      = PC_W'(outBundle_s.pc);
`ifdef DECODE_ILLEGAL_TRAP_EN
  assign bus.IllegalInstr = outBundle_s.illegal;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: self-checking bench for instr_decode_stage.
// Table of decode vectors plus hand-written backpressure, flush and
// asynchronous-reset sequences. Honours DECODE_ILLEGAL_TRAP_EN.
module tb_instr_decode_stage;
  import mips_decode_pkg::*;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  instr_decode_stage_if #(.PC_W(32)) bus ();

  instr_decode_stage #(.PC_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  sh;
    logic [5:0]  fn;
    logic [15:0] imm;
    logic        zx;
    logic [25:0] jt;
    logic        ill;
  } vec_t;

  vec_t vecs[8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] pc);
    bus.Instr   = instr;
    bus.PcIn    = pc;
    bus.InValid = 1'b1;
  endtask

  initial begin
    //               instr          pc             op     rs     rt     rd     sh     fn     imm       zx    jt              ill
    vecs[0] = '{32'h3508_1234, 32'h0040_0000, 6'h0D, 5'd8,  5'd8,  5'd2,  5'd8,  6'h34, 16'h1234, 1'b1, 26'h108_1234, 1'b0};
    vecs[1] = '{32'h2009_FFFF, 32'h0040_0004, 6'h08, 5'd0,  5'd9,  5'd31, 5'd31, 6'h3F, 16'hFFFF, 1'b0, 26'h009_FFFF, 1'b0};
    vecs[2] = '{32'h0128_5020, 32'h0040_0008, 6'h00, 5'd9,  5'd8,  5'd10, 5'd0,  6'h20, 16'h5020, 1'b0, 26'h128_5020, 1'b0};
    vecs[3] = '{32'h8C88_0004, 32'h0040_000C, 6'h23, 5'd4,  5'd8,  5'd0,  5'd0,  6'h04, 16'h0004, 1'b0, 26'h088_0004, 1'b0};
    vecs[4] = '{32'h3A0F_00FF, 32'h0040_0010, 6'h0E, 5'd16, 5'd15, 5'd0,  5'd3,  6'h3F, 16'h00FF, 1'b1, 26'h20F_00FF, 1'b0};
    vecs[5] = '{32'h3000_0000, 32'h0040_0014, 6'h0C, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b1, 26'h000_0000, 1'b0};
    vecs[6] = '{32'h3C01_0010, 32'h0040_0018, 6'h0F, 5'd0,  5'd1,  5'd0,  5'd0,  6'h10, 16'h0010, 1'b0, 26'h001_0010, 1'b0};
    vecs[7] = '{32'hFC00_0000, 32'hFFFF_FFFC, 6'h3F, 5'd0,  5'd0,  5'd0,  5'd0,  6'h00, 16'h0000, 1'b0, 26'h000_0000, 1'b1};

    rst_n        = 1'b0;
    bus.Flush    = 1'b0;
    bus.InValid  = 1'b0;
    bus.Instr    = 32'h0;
    bus.PcIn     = 32'h0;
    bus.OutReady = 1'b1;

    // Reset state
    #3;
    chk("reset OutValid", 32'(bus.OutValid), 32'h0);
    chk("reset InReady", 32'(bus.InReady), 32'h0);
    chk("reset PcOut", bus.PcOut, 32'h0);
    chk("reset Opcode", 32'(bus.Opcode), 32'h0);
    #9 rst_n = 1'b1;
    tick();
    chk("post-reset InReady", 32'(bus.InReady), 32'h1);
    chk("post-reset OutValid", 32'(bus.OutValid), 32'h0);

    // Decode table, one instruction at a time with OutReady=1
    for (int i = 0; i < 8; i++) begin
      offer(vecs[i].instr, vecs[i].pc);
      tick();
      bus.InValid = 1'b0;
      chk("vec OutValid", 32'(bus.OutValid), 32'h1);
      chk("vec Opcode", 32'(bus.Opcode), 32'(vecs[i].op));
      chk("vec Rs", 32'(bus.Rs), 32'(vecs[i].rs));
      chk("vec Rt", 32'(bus.Rt), 32'(vecs[i].rt));
      chk("vec Rd", 32'(bus.Rd), 32'(vecs[i].rd));
      chk("vec Shamt", 32'(bus.Shamt), 32'(vecs[i].sh));
      chk("vec Funct", 32'(bus.Funct), 32'(vecs[i].fn));
      chk("vec ImmIn", 32'(bus.ImmIn), 32'(vecs[i].imm));
      chk("vec ZeroExtend", 32'(bus.ZeroExtend), 32'(vecs[i].zx));
      chk("vec JumpTarget", 32'(bus.JumpTarget), 32'(vecs[i].jt));
      chk("vec PcOut", bus.PcOut, vecs[i].pc);
`ifdef DECODE_ILLEGAL_TRAP_EN
      chk("vec IllegalInstr", 32'(bus.IllegalInstr), 32'(vecs[i].ill));
`endif
      tick();
      chk("vec drained OutValid", 32'(bus.OutValid), 32'h0);
      chk("vec drained InReady", 32'(bus.InReady), 32'h1);
    end

    // Backpressure: A, B accepted; C held off until the skid drains
    bus.OutReady = 1'b0;
    offer(vecs[0].instr, 32'h0000_1000);
    tick();
    chk("bp A OutValid", 32'(bus.OutValid), 32'h1);
    chk("bp A PcOut", bus.PcOut, 32'h0000_1000);
    chk("bp InReady after A", 32'(bus.InReady), 32'h1);
    offer(vecs[1].instr, 32'h0000_1004);
    tick();
    chk("bp InReady after B", 32'(bus.InReady), 32'h0);
    chk("bp A held PcOut", bus.PcOut, 32'h0000_1000);
    chk("bp A held Opcode", 32'(bus.Opcode), 32'h0D);
    offer(vecs[2].instr, 32'h0000_1008);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp stall InReady", 32'(bus.InReady), 32'h0);
      chk("bp stall OutValid", 32'(bus.OutValid), 32'h1);
      chk("bp stall PcOut", bus.PcOut, 32'h0000_1000);
      chk("bp stall ImmIn", 32'(bus.ImmIn), 32'h1234);
    end
    bus.OutReady = 1'b1;
    tick();
    chk("bp B PcOut", bus.PcOut, 32'h0000_1004);
    chk("bp B Opcode", 32'(bus.Opcode), 32'h08);
    chk("bp B OutValid", 32'(bus.OutValid), 32'h1);
    chk("bp InReady after drain", 32'(bus.InReady), 32'h1);
    tick();
    bus.InValid = 1'b0;
    chk("bp C PcOut", bus.PcOut, 32'h0000_1008);
    chk("bp C Funct", 32'(bus.Funct), 32'h20);
    chk("bp C OutValid", 32'(bus.OutValid), 32'h1);
    tick();
    chk("bp empty OutValid", 32'(bus.OutValid), 32'h0);

    // Flush with both entries full and a new instruction offered
    bus.OutReady = 1'b0;
    offer(vecs[3].instr, 32'h0000_2000);
    tick();
    offer(vecs[4].instr, 32'h0000_2004);
    tick();
    chk("flush pre InReady", 32'(bus.InReady), 32'h0);
    offer(vecs[5].instr, 32'h0000_2008);
    bus.Flush    = 1'b1;
    bus.OutReady = 1'b1;
    tick();
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    chk("flush OutValid", 32'(bus.OutValid), 32'h0);
    chk("flush InReady", 32'(bus.InReady), 32'h1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("flush stays empty", 32'(bus.OutValid), 32'h0);
    end

    // Asynchronous reset while OutValid=1
    bus.OutReady = 1'b0;
    offer(vecs[6].instr, 32'h0000_3000);
    tick();
    bus.InValid = 1'b0;
    chk("areset pre OutValid", 32'(bus.OutValid), 32'h1);
    #3 rst_n = 1'b0;
    #1;
    chk("areset OutValid", 32'(bus.OutValid), 32'h0);
    chk("areset InReady", 32'(bus.InReady), 32'h0);
    chk("areset PcOut", bus.PcOut, 32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("areset release InReady", 32'(bus.InReady), 32'h1);
    chk("areset release OutValid", 32'(bus.OutValid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
